// File: rtl/survivor_mem.sv
// Circular survivor-decision store between the Viterbi ACS array and the traceback unit.
// Holds D columns of 2^M decision bits and launches one traceback per column once full.
module survivor_mem #(
    parameter int K  = 7,
    parameter int M  = K - 1,
    parameter int D  = 40,
    parameter int NS = 1 << M,
    localparam int PW = $clog2(D),
    localparam int FW = $clog2(D + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          dec_valid,
    input  logic [NS-1:0] dec_vec,
    input  logic [M-1:0]  best_state,
    output logic [PW-1:0] wr_ptr,
    output logic [M-1:0]  s_end,
    output logic          force_state0,
    input  logic [PW-1:0] tb_time,
    input  logic [M-1:0]  tb_state,
    output logic          tb_surv_bit,
    input  logic          tb_done,
    output logic          full,
    output logic          overrun
);

    localparam logic [FW-1:0] FILL_MAX = FW'(D);
    localparam logic [PW-1:0] PTR_LAST = PW'(D - 1);
    localparam logic [PW:0]   TIME_LIM = (PW + 1)'(D);

    logic [NS-1:0] mem [D];

    logic [FW-1:0] fill;
    logic [FW-1:0] fill_nxt;
    logic          busy;
    logic          pending;
    logic          req;
    logic          launch;
    logic          busy_nxt;
    logic          pending_nxt;
    logic          overrun_nxt;

    always_comb begin
        fill_nxt = (fill == FILL_MAX) ? FILL_MAX : fill + FW'(1);
        req      = dec_valid && (fill_nxt == FILL_MAX);
    end

    // A request colliding with tb_done is queued; busy drops so the pending launch fires next edge.
    always_comb begin
        launch      = 1'b0;
        busy_nxt    = busy;
        pending_nxt = pending;
        overrun_nxt = overrun;
        if (req && !busy) begin
            launch      = 1'b1;
            busy_nxt    = 1'b1;
            pending_nxt = 1'b0;
        end else if (req) begin
            pending_nxt = 1'b1;
            overrun_nxt = 1'b1;
            if (tb_done) begin
                busy_nxt = 1'b0;
            end
        end else if (pending && (tb_done || !busy)) begin
            launch      = 1'b1;
            busy_nxt    = 1'b1;
            pending_nxt = 1'b0;
        end else if (tb_done) begin
            busy_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr       <= '0;
            s_end        <= '0;
            fill         <= '0;
            full         <= 1'b0;
            busy         <= 1'b0;
            pending      <= 1'b0;
            overrun      <= 1'b0;
            force_state0 <= 1'b0;
        end else begin
            if (dec_valid) begin
                wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PW'(1);
                s_end  <= best_state;
                fill   <= fill_nxt;
                full   <= (fill_nxt == FILL_MAX);
            end
            busy         <= busy_nxt;
            pending      <= pending_nxt;
            overrun      <= overrun_nxt;
            force_state0 <= launch;
        end
    end

    // Decision storage carries no reset; contents are only valid once written.
    always_ff @(posedge clk) begin
        if (dec_valid) begin
            mem[wr_ptr] <= dec_vec;
        end
    end

    // Registered read port: a same-column write on this edge is not visible until the next read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tb_surv_bit <= 1'b0;
        end else begin
            tb_surv_bit <= ({1'b0, tb_time} < TIME_LIM) ? mem[tb_time][tb_state] : 1'b0;
        end
    end

endmodule

// File: tb/tb_survivor_mem.sv
// Bench for survivor_mem: fill/launch sequencing, read port table, overrun, wrap and async reset.
module tb_survivor_mem;

    localparam int D  = 40;
    localparam int M  = 6;
    localparam int NS = 64;
    localparam int PW = 6;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          dec_valid = 1'b0;
    logic [NS-1:0] dec_vec = '0;
    logic [M-1:0]  best_state = '0;
    logic [PW-1:0] wr_ptr;
    logic [M-1:0]  s_end;
    logic          force_state0;
    logic [PW-1:0] tb_time = '0;
    logic [M-1:0]  tb_state = '0;
    logic          tb_surv_bit;
    logic          tb_done = 1'b0;
    logic          full;
    logic          overrun;

    survivor_mem #(.K(7), .D(D)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .dec_valid    (dec_valid),
        .dec_vec      (dec_vec),
        .best_state   (best_state),
        .wr_ptr       (wr_ptr),
        .s_end        (s_end),
        .force_state0 (force_state0),
        .tb_time      (tb_time),
        .tb_state     (tb_state),
        .tb_surv_bit  (tb_surv_bit),
        .tb_done      (tb_done),
        .full         (full),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;
    int force_cnt = 0;
    bit exp_q[$];

    typedef struct {
        logic [PW-1:0] t;
        logic [M-1:0]  s;
        bit            e;
    } rd_vec_t;

    rd_vec_t tbl[12];

    always @(negedge clk) begin
        if (force_state0 === 1'b1) force_cnt++;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, time %0t required below 300000", $time);
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_col(input logic [NS-1:0] v, input logic [M-1:0] bs);
        dec_valid  = 1'b1;
        dec_vec    = v;
        best_state = bs;
        step();
        dec_valid  = 1'b0;
    endtask

    task automatic rd_issue(input logic [PW-1:0] t, input logic [M-1:0] s, input bit e);
        tb_time  = t;
        tb_state = s;
        exp_q.push_back(e);
    endtask

    task automatic rd_check(input string name);
        bit e;
        if (exp_q.size() == 0) begin
            checks++;
            $display("FAIL %s: scoreboard empty, got %0b with no expectation", name, tb_surv_bit);
        end else begin
            e = exp_q.pop_front();
            check(name, 64'(tb_surv_bit), 64'(e));
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_wr_ptr"},  64'(wr_ptr), 0);
        check({tag, "_s_end"},   64'(s_end), 0);
        check({tag, "_force"},   64'(force_state0), 0);
        check({tag, "_surv"},    64'(tb_surv_bit), 0);
        check({tag, "_full"},    64'(full), 0);
        check({tag, "_overrun"}, 64'(overrun), 0);
    endtask

    function automatic logic [63:0] col_pat(input int i);
        if (i == 7) return 64'h1 << 19;
        return ~(64'h1 << i);
    endfunction

    initial begin
        int fc0;
        int bad;

        tbl[0]  = '{6'd7,  6'd19, 1'b1};
        tbl[1]  = '{6'd7,  6'd18, 1'b0};
        tbl[2]  = '{6'd7,  6'd7,  1'b0};
        tbl[3]  = '{6'd40, 6'd19, 1'b0};
        tbl[4]  = '{6'd63, 6'd5,  1'b0};
        tbl[5]  = '{6'd3,  6'd3,  1'b0};
        tbl[6]  = '{6'd3,  6'd4,  1'b1};
        tbl[7]  = '{6'd0,  6'd0,  1'b0};
        tbl[8]  = '{6'd0,  6'd63, 1'b1};
        tbl[9]  = '{6'd39, 6'd39, 1'b0};
        tbl[10] = '{6'd39, 6'd38, 1'b1};
        tbl[11] = '{6'd20, 6'd21, 1'b1};

        #2 rst_n = 1'b0;
        #1;
        check_all_zero("reset");
        step();
        step();
        rst_n = 1'b1;
        step();

        // Fill to D-1 columns, 5 cycles apart: no launch yet
        for (int i = 0; i < D - 1; i++) begin
            write_col(col_pat(i), M'(i));
            repeat (4) step();
        end
        check("prefill_no_launch", 64'(force_cnt), 0);
        check("prefill_full", 64'(full), 0);
        check("prefill_wr_ptr", 64'(wr_ptr), 39);
        check("prefill_s_end", 64'(s_end), 38);

        // D-th column launches exactly one traceback
        write_col(col_pat(39), 6'h2A);
        check("launch_force", 64'(force_state0), 1);
        check("launch_wr_ptr", 64'(wr_ptr), 0);
        check("launch_s_end", 64'(s_end), 64'h2A);
        check("launch_full", 64'(full), 1);
        step();
        check("launch_one_cycle", 64'(force_state0), 0);
        check("launch_count", 64'(force_cnt), 1);

        for (int i = 0; i < 12; i++) begin
            rd_issue(tbl[i].t, tbl[i].s, tbl[i].e);
            step();
            rd_check($sformatf("read_tbl%0d", i));
        end

        // Write while busy: overrun, no pulse; read-first on the written column
        fc0 = force_cnt;
        rd_issue(6'd0, 6'd0, 1'b0);
        write_col('1, 6'h11);
        rd_check("read_first_old");
        check("busy_write_overrun", 64'(overrun), 1);
        check("busy_write_no_force", 64'(force_state0), 0);
        check("busy_write_wr_ptr", 64'(wr_ptr), 1);
        rd_issue(6'd0, 6'd0, 1'b1);
        step();
        rd_check("read_after_write_new");
        check("busy_write_no_pulse", 64'(force_cnt - fc0), 0);
        tb_done = 1'b1;
        step();
        tb_done = 1'b0;
        check("pending_relaunch", 64'(force_state0), 1);
        check("pending_relaunch_wr_ptr", 64'(wr_ptr), 1);
        check("pending_relaunch_s_end", 64'(s_end), 64'h11);
        check("overrun_sticky", 64'(overrun), 1);
        step();
        check("relaunch_one_cycle", 64'(force_state0), 0);
        tb_done = 1'b1;
        step();
        tb_done = 1'b0;

        // Wrap at sustainable rate with traceback completions
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        check("wrap_start_overrun", 64'(overrun), 0);
        fc0 = force_cnt;
        bad = 0;
        for (int n = 0; n < 2 * D + 3; n++) begin
            write_col('1, M'(n));
            if (n >= D - 1) begin
                if (force_state0 !== 1'b1) bad++;
            end else if (force_state0 !== 1'b0) begin
                bad++;
            end
            for (int j = 0; j < D + 2; j++) begin
                tb_done = (n >= D - 1) && (j == D);
                step();
            end
            tb_done = 1'b0;
        end
        check("wrap_wr_ptr", 64'(wr_ptr), 3);
        check("wrap_overrun", 64'(overrun), 0);
        check("wrap_launch_timing", 64'(bad), 0);
        check("wrap_launch_count", 64'(force_cnt - fc0), 44);
        check("wrap_full", 64'(full), 1);

        // Busy and pending, then asynchronous reset mid-traceback
        write_col('1, 6'h05);
        check("pre_rst_launch", 64'(force_state0), 1);
        step();
        write_col('1, 6'h06);
        check("pre_rst_overrun", 64'(overrun), 1);
        rd_issue(6'd5, 6'd0, 1'b1);
        step();
        rd_check("pre_rst_read");
        #2 rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        step();
        rst_n = 1'b1;
        fc0 = force_cnt;
        tb_done = 1'b1;
        step();
        tb_done = 1'b0;
        step();
        check("rst_cleared_pending", 64'(force_cnt - fc0), 0);
        for (int i = 0; i < D - 1; i++) begin
            write_col(col_pat(i), M'(i));
        end
        step();
        check("rst_refill_no_launch", 64'(force_cnt - fc0), 0);
        check("rst_refill_full", 64'(full), 0);
        write_col(col_pat(39), 6'h3C);
        check("rst_refill_launch", 64'(force_state0), 1);
        check("rst_refill_s_end", 64'(s_end), 64'h3C);
        step();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/survivor_mem.md
# survivor_mem

Circular survivor-decision store for the K-constraint Viterbi decoder, sitting between the ACS array and the traceback unit. Each accepted symbol step writes one 2^M-bit decision column plus the best end state. Once D columns are held, it launches one traceback per new column via a single-cycle `force_state0` pulse. It serves the traceback read port with a fixed one-cycle registered read.

## Interface
- `K`, 7, constraint length
- `M`, K-1, state bits
- `D`, 40, traceback depth = column count of circular buffer
- `NS`, 1<<M, states per column
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `dec_valid`  in  1  column write strobe from ACS
- `dec_vec`  in  NS  decision bits; bit s = survivor bit of state s
- `best_state`  in  M  minimum-metric state for this column
- `wr_ptr`  out  $clog2(D)  index of next column to be written
- `s_end`  out  M  best_state of most recently written column
- `force_state0`  out  1  one-cycle traceback launch pulse
- `tb_time`  in  $clog2(D)  read column
- `tb_state`  in  M  read state
- `tb_surv_bit`  out  1  registered read data mem[tb_time][tb_state]
- `tb_done`  in  1  traceback completion (tie to dec_bit_valid)
- `full`  out  1  D columns written since reset
- `overrun`  out  1  sticky: column written while traceback busy

## Operation
- Storage: D x NS bits, not reset. Internal: fill counter 0..D (saturating), `busy`, `pending`.
- Write (dec_valid=1 at edge): mem[wr_ptr] <= dec_vec; s_end <= best_state; wr_ptr <= (wr_ptr==D-1) ? 0 : wr_ptr+1; fill <= min(fill+1, D); full <= (fill+1 >= D).
- Launch request = write edge whose post-write fill == D. No launch while fill < D.
- Launch arbitration at each edge, priority order:
  - request and !busy: force_state0 <= 1, busy <= 1.
  - request and busy: pending <= 1, overrun <= 1 (column write into the active window corrupts it; write still performed).
  - tb_done and pending (no request): force_state0 <= 1, busy stays 1, pending <= 0.
  - tb_done and !pending: busy <= 0.
  - Request and tb_done on the same edge: treated as busy; pending set, overrun set, launch occurs on the following edge.
- force_state0 is cleared every edge it is not set; never high two consecutive cycles.
- Read: every edge, tb_surv_bit <= (tb_time < D) ? mem[tb_time][tb_state] : 0. Same-column read and write on one edge returns old data (read-first).
- overrun clears only on reset.
- Reset (rst_n low, any time, including mid-traceback): wr_ptr=0, s_end=0, force_state0=0, tb_surv_bit=0, full=0, overrun=0, fill=0, busy=0, pending=0. Effect is immediate and asynchronous. Release is synchronised externally.

## Timing
- Write at edge E: wr_ptr, s_end and full are updated after E. force_state0 is high for the cycle E..E+1, concurrent with the updated wr_ptr/s_end, so traceback samples consistent values at E+1.
- Read latency is exactly 1 cycle: tb_time/tb_state presented before edge E give valid tb_surv_bit after E.
- Re-launch from pending: tb_done high in cycle C gives force_state0 high in cycle C+1.
- Sustainable rate without overrun: one dec_valid per D+3 cycles (traceback occupancy INIT + D + OUTPUT, plus launch).
- No combinational path from any input to any output.

## Test plan
- Reset, then write D-1 columns 5 cycles apart: force_state0 never asserts, full=0, wr_ptr=D-1.
- Write the D-th column with best_state=0x2A: next cycle force_state0=1 for exactly one cycle, wr_ptr=0, s_end=0x2A, full=1.
- Write the column at index 7 with dec_vec bit 19 = 1 and all other bits 0. Drive tb_time=7, tb_state=19: tb_surv_bit=1 one cycle later. tb_state=18 gives 0. tb_time=D gives 0.
- Buffer full, busy: write a column before tb_done: overrun=1, no immediate pulse. Pulse tb_done: force_state0=1 the next cycle with the new wr_ptr.
- Wrap: write 2D+3 columns spaced D+3 cycles apart: wr_ptr=3, one launch per column after the D-th, overrun=0.
- Assert rst_n low mid-traceback with busy=1 and pending=1: all outputs return to zero immediately. After release, the first launch occurs only after D new columns.
